alu16: RTL and testbench

//  16-bit signed ALU for the memory-to-memory datapath: add/sub, bitwise logic,

---
 rtl/alu16.sv | 101 ++++++++++
 tb/tb_alu16.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu16.sv
// alu16: 16-bit signed ALU with a registered result and a registered compare flag.
// Combinational operation decode feeds a single register stage (one-cycle latency).
module alu16 (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [3:0]  ALUOp,
    output logic [15:0] outputValue,
    output logic        isTrue
);

    // Opcode map
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_NE  = 4'd8;
    localparam logic [3:0] OP_LT  = 4'd9;
    localparam logic [3:0] OP_GE  = 4'd10;
    localparam logic [3:0] OP_LE  = 4'd11;
    localparam logic [3:0] OP_GT  = 4'd12;

    logic [15:0] result_d, result_q;
    logic        flag_d,   flag_q;

    // Logarithmic shifters: stage gi shifts by 2**gi when B[gi] is set.
    logic [4:0][15:0] shl_stage;
    logic [4:0][15:0] shr_stage;
    // Any bit above B[3] means the amount is >= 16 (negative B included): result is 0.
    logic             shift_oob;

    assign shl_stage[0] = A;
    assign shr_stage[0] = A;
    assign shift_oob    = |B[15:4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shift
            localparam int AMT = 1 << gi;
            assign shl_stage[gi+1] = B[gi] ? (shl_stage[gi] << AMT) : shl_stage[gi];
            assign shr_stage[gi+1] = B[gi] ? (shr_stage[gi] >> AMT) : shr_stage[gi];
        end
    endgenerate

    // Signed views of the operands for the compare group
    logic signed [15:0] a_s, b_s;
    logic               lt_s, eq_s;

    assign a_s  = $signed(A);
    assign b_s  = $signed(B);
    assign lt_s = (a_s < b_s);
    assign eq_s = (A == B);

    // Operation decode: result and flag for the current operands
    always_comb begin
        result_d = 16'd0;
        flag_d   = 1'b0;
        case (ALUOp)
            OP_ADD: result_d = A + B;
            OP_SUB: result_d = A - B;
            OP_OR:  result_d = A | B;
            OP_AND: result_d = A & B;
            OP_XOR: result_d = A ^ B;
            OP_SHL: result_d = shift_oob ? 16'd0 : shl_stage[4];
            OP_SHR: result_d = shift_oob ? 16'd0 : shr_stage[4];
            OP_EQ:  flag_d   = eq_s;
            OP_NE:  flag_d   = ~eq_s;
            OP_LT:  flag_d   = lt_s;
            OP_GE:  flag_d   = ~lt_s;
            OP_LE:  flag_d   = lt_s | eq_s;
            OP_GT:  flag_d   = ~(lt_s | eq_s);
            default: begin
                result_d = 16'd0;
                flag_d   = 1'b0;
            end
        endcase
        // Compares also publish the flag in bit 0 of the result
        if (ALUOp >= OP_EQ && ALUOp <= OP_GT) begin
            result_d = {15'd0, flag_d};
        end
    end

    // Output register; Reset overrides any operation
    always_ff @(posedge CLK) begin
        if (Reset) begin
            result_q <= 16'd0;
            flag_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign outputValue = result_q;
    assign isTrue      = flag_q;

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: table-driven vectors plus reset sequences and random operands,
// expected results queued at drive time and checked one edge later.
module tb_alu16;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] A, B;
    logic [3:0]  ALUOp;
    logic [15:0] outputValue;
    logic        isTrue;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_val;
        logic        exp_flag;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp_val;
        logic        exp_flag;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    alu16 dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .A          (A),
        .B          (B),
        .ALUOp      (ALUOp),
        .outputValue(outputValue),
        .isTrue     (isTrue)
    );

    always #5 CLK = ~CLK;

    // Independent reference for random operands
    function automatic void ref_model(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b,
                                      output logic [15:0] v, output logic f);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        v = 16'd0;
        f = 1'b0;
        case (op)
            4'd0: v = 16'((a + b) & 16'hFFFF);
            4'd1: v = 16'((a - b) & 16'hFFFF);
            4'd2: v = a | b;
            4'd3: v = a & b;
            4'd4: v = a ^ b;
            4'd5: v = (int'(b) >= 16) ? 16'd0 : 16'(a << int'(b));
            4'd6: v = (int'(b) >= 16) ? 16'd0 : 16'(a >> int'(b));
            4'd7: f = (sa == sb);
            4'd8: f = (sa != sb);
            4'd9: f = (sa < sb);
            4'd10: f = (sa >= sb);
            4'd11: f = (sa <= sb);
            4'd12: f = (sa > sb);
            default: ;
        endcase
        if (op >= 4'd7 && op <= 4'd12) v = {15'd0, f};
    endfunction

    // Drive one operation on the falling edge and queue what it must produce
    task automatic drive(input string name, input logic rst, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ev, input logic ef);
        exp_t e;
        @(negedge CLK);
        Reset = rst;
        ALUOp = op;
        A     = a;
        B     = b;
        e.name     = name;
        e.exp_val  = ev;
        e.exp_flag = ef;
        sb_q.push_back(e);
    endtask

    // Monitor: each queued entry was sampled at this edge; check it just after
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (outputValue !== e.exp_val) begin
                bad++;
                $display("FAIL %s: outputValue got %h want %h", e.name, outputValue, e.exp_val);
            end
            total++;
            if (isTrue !== e.exp_flag) begin
                bad++;
                $display("FAIL %s: isTrue got %b want %b", e.name, isTrue, e.exp_flag);
            end
            $display("chk %s: val=%h flag=%b", e.name, outputValue, isTrue);
        end
    end

    initial begin
        logic [15:0] ra, rb, rv;
        logic [3:0]  rop;
        logic        rf;
        int          waited;

        vecs = '{
            '{"add_100_30",  4'd0,  16'd100,  16'd30,   16'd130,  1'b0},
            '{"add_m1_5",    4'd0,  16'hFFFF, 16'd5,    16'd4,    1'b0},
            '{"add_0_0",     4'd0,  16'd0,    16'd0,    16'd0,    1'b0},
            '{"add_wrap",    4'd0,  16'h7FFF, 16'd1,    16'h8000, 1'b0},
            '{"sub_55_5",    4'd1,  16'd55,   16'd5,    16'd50,   1'b0},
            '{"sub_m1_5",    4'd1,  16'hFFFF, 16'd5,    16'hFFFA, 1'b0},
            '{"sub_20_20",   4'd1,  16'd20,   16'd20,   16'd0,    1'b0},
            '{"or",          4'd2,  16'hAAAA, 16'h5555, 16'hFFFF, 1'b0},
            '{"and",         4'd3,  16'hFEAA, 16'h55FF, 16'h54AA, 1'b0},
            '{"xor",         4'd4,  16'hBFC0, 16'hF03F, 16'h4FFF, 1'b0},
            '{"shl_ffff_5",  4'd5,  16'hFFFF, 16'd5,    16'hFFE0, 1'b0},
            '{"shl_1_10",    4'd5,  16'd1,    16'd10,   16'h0400, 1'b0},
            '{"shr_ffe0_5",  4'd6,  16'hFFE0, 16'd5,    16'h07FF, 1'b0},
            '{"shr_1000_5",  4'd6,  16'h1000, 16'd5,    16'h0080, 1'b0},
            '{"shl_1_16",    4'd5,  16'd1,    16'd16,   16'd0,    1'b0},
            '{"shr_neg_b",   4'd6,  16'h8000, 16'hFFFF, 16'd0,    1'b0},
            '{"shl_by_0",    4'd5,  16'h1234, 16'd0,    16'h1234, 1'b0},
            '{"shr_8000_15", 4'd6,  16'h8000, 16'd15,   16'h0001, 1'b0},
            '{"eq_m1_m1",    4'd7,  16'hFFFF, 16'hFFFF, 16'd1,    1'b1},
            '{"add_after_eq",4'd0,  16'd1,    16'd1,    16'd2,    1'b0},
            '{"eq_1_2",      4'd7,  16'd1,    16'd2,    16'd0,    1'b0},
            '{"ne_1_m1",     4'd8,  16'd1,    16'hFFFF, 16'd1,    1'b1},
            '{"ne_3_3",      4'd8,  16'd3,    16'd3,    16'd0,    1'b0},
            '{"lt_m100_5",   4'd9,  16'hFF9C, 16'd5,    16'd1,    1'b1},
            '{"lt_5_5",      4'd9,  16'd5,    16'd5,    16'd0,    1'b0},
            '{"lt_min_max",  4'd9,  16'h8000, 16'h7FFF, 16'd1,    1'b1},
            '{"ge_10_m1",    4'd10, 16'd10,   16'hFFFF, 16'd1,    1'b1},
            '{"ge_min_max",  4'd10, 16'h8000, 16'h7FFF, 16'd0,    1'b0},
            '{"le_5_5",      4'd11, 16'd5,    16'd5,    16'd1,    1'b1},
            '{"le_m1_m2",    4'd11, 16'hFFFF, 16'hFFFE, 16'd0,    1'b0},
            '{"gt_0_m5",     4'd12, 16'd0,    16'hFFFB, 16'd1,    1'b1},
            '{"gt_5_10",     4'd12, 16'd5,    16'd10,   16'd0,    1'b0},
            '{"rsv_13",      4'd13, 16'hFFFF, 16'hFFFF, 16'd0,    1'b0},
            '{"rsv_14",      4'd14, 16'd7,    16'd7,    16'd0,    1'b0},
            '{"rsv_15",      4'd15, 16'hAAAA, 16'h5555, 16'd0,    1'b0}
        };

        Reset = 1'b1;
        ALUOp = 4'd0;
        A     = 16'd0;
        B     = 16'd0;

        // Reset state
        drive("reset0", 1'b1, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        drive("reset1", 1'b1, 4'd7, 16'd3, 16'd3, 16'd0, 1'b0);

        // Table vectors, back to back
        foreach (vecs[i])
            drive(vecs[i].name, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_val, vecs[i].exp_flag);

        // Reset wins over an ADD in flight, then a new op shows one edge after release
        drive("pre_rst_eq", 1'b0, 4'd7, 16'd9, 16'd9, 16'd1, 1'b1);
        drive("rst_during_add", 1'b1, 4'd0, 16'd100, 16'd30, 16'd0, 1'b0);
        drive("after_release", 1'b0, 4'd0, 16'd100, 16'd30, 16'd130, 1'b0);
        drive("next_op", 1'b0, 4'd12, 16'd7, 16'd3, 16'd1, 1'b1);

        // Random operands against the reference
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = (rop == 4'd5 || rop == 4'd6) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            ref_model(rop, ra, rb, rv, rf);
            drive($sformatf("rnd%0d_op%0d", n, rop), 1'b0, rop, ra, rb, rv, rf);
        end

        // Let the last result come out, bounded
        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge CLK);
            #2;
            waited++;
        end
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending got %0d want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
